// File: rtl/tp_ram_be_if.sv
// tp_ram_be port bundle: byte-enabled write port, read port, ready flag.
interface tp_ram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  init_done;
  logic                  en_wr;
  logic [NB-1:0]         be_wr;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  en_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [DATA_WIDTH-1:0] data_rd;
  logic                  valid_rd;

  modport master (
    input  init_done, data_rd, valid_rd,
    output en_wr, be_wr, addr_wr, data_wr,
    output en_rd, addr_rd
  );

  modport slave (
    output init_done, data_rd, valid_rd,
    input  en_wr, be_wr, addr_wr, data_wr,
    input  en_rd, addr_rd
  );
endinterface

// File: rtl/tp_ram_be.sv
// Simple dual-port RAM, byte enables, N-stage read pipe, post-reset clear.
// Define TP_RAM_BYPASS_EN for write-first same-address forwarding.
module tp_ram_be #(
  parameter int    DEPTH      = 16,
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 4,
  parameter int    BYTE_WIDTH = 8,
  parameter int    OUTPUT_REG = 1,
  parameter int    INIT_CLEAR = 1,
  parameter string RAM_TYPE   = "block"
) (
  input logic        clk,
  input logic        rst_n,
  tp_ram_be_if.slave bus
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int BW = BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH-1);

  if (DATA_WIDTH % BYTE_WIDTH != 0)
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  if ((1 << ADDR_WIDTH) < DEPTH)
    $error("ADDR_WIDTH too small for DEPTH");
  if (OUTPUT_REG < 1)
    $error("OUTPUT_REG must be >= 1");
  if (RAM_TYPE != "block" && RAM_TYPE != "distributed" &&
      RAM_TYPE != "register" && RAM_TYPE != "ultra")
    $error("unsupported RAM_TYPE");
  if ($bits(bus.data_wr) != DATA_WIDTH || $bits(bus.addr_wr) != ADDR_WIDTH)
    $error("interface widths do not match");

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done;
  logic                  clr_we;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rd_in;
  logic [DATA_WIDTH-1:0] rd_word;

  (* ram_style = RAM_TYPE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] st_data_q [OUTPUT_REG];
  logic [DATA_WIDTH-1:0] st_data_d [OUTPUT_REG];
  logic [OUTPUT_REG-1:0] st_vld_q, st_vld_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? S_CLEAR : S_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_READY;
      end
      default: ;
    endcase
  end

  // The clear write must not fire on a reset edge.
  always_comb begin
    init_done = 1'b0;
    clr_we    = 1'b0;
    case (state_q)
      S_CLEAR: clr_we    = rst_n;
      S_READY: init_done = 1'b1;
      default: ;
    endcase
  end

  assign wr_ok = rst_n & init_done & bus.en_wr &
                 ({1'b0, bus.addr_wr} < DEPTH_X);
  assign rd_ok = init_done & bus.en_rd;
  assign rd_in = {1'b0, bus.addr_rd} < DEPTH_X;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NB; k++)
        if (bus.be_wr[k])
          mem[bus.addr_wr][k*BW +: BW] <= bus.data_wr[k*BW +: BW];
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      rd_word = mem[bus.addr_rd];
`ifdef TP_RAM_BYPASS_EN
      if (wr_ok && bus.addr_wr == bus.addr_rd)
        for (int k = 0; k < NB; k++)
          if (bus.be_wr[k])
            rd_word[k*BW +: BW] = bus.data_wr[k*BW +: BW];
`endif
    end
  end

  // Data stages only load behind a valid, so the output holds between reads.
  always_comb begin
    st_data_d    = st_data_q;
    st_vld_d     = '0;
    st_vld_d[0]  = rd_ok;
    if (rd_ok) st_data_d[0] = rd_word;
    for (int i = 1; i < OUTPUT_REG; i++) begin
      st_vld_d[i] = st_vld_q[i-1];
      if (st_vld_q[i-1]) st_data_d[i] = st_data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_vld_q <= '0;
      for (int i = 0; i < OUTPUT_REG; i++) st_data_q[i] <= '0;
    end else begin
      st_vld_q  <= st_vld_d;
      st_data_q <= st_data_d;
    end
  end

  assign bus.init_done = init_done;
  assign bus.data_rd   = st_data_q[OUTPUT_REG-1];
  assign bus.valid_rd  = st_vld_q[OUTPUT_REG-1];
endmodule

// File: doc/tp_ram_be.md
Name: tp_ram_be

Overview:
Single-clock simple-dual-port RAM with per-byte write enables, a parametrised read pipeline with valid tracking, and a post-reset clear sequencer. It is the next generation of the team's two-port RAM primitive, intended for the sync FIFO, packet buffers and descriptor tables. One write port and one read port share one clock. Reads always have fixed, known latency with a qualifying valid.

Parameters:
DEPTH, 16, number of words; need not be a power of two.
DATA_WIDTH, 32, word width in bits; must be an integer multiple of BYTE_WIDTH (elaboration $error otherwise).
ADDR_WIDTH, 4, address width; must satisfy 2**ADDR_WIDTH >= DEPTH (elaboration $error otherwise).
BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH lanes.
OUTPUT_REG, 1, read latency in cycles; must be >= 1 (elaboration $error on 0).
INIT_CLEAR, 1, 1 = zero every word after reset before accepting traffic; 0 = no clear.
RAM_TYPE, "block", ram_style attribute: block | distributed | register | ultra; any other value is an elaboration $error.

Ports:
clk  input  1  single clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset.
init_done  output  1  1 = RAM ready; en_wr and en_rd are honoured only when 1.
en_wr  input  1  write request.
be_wr  input  NB  per-lane write enable; bit k covers data_wr[k*BYTE_WIDTH +: BYTE_WIDTH].
addr_wr  input  ADDR_WIDTH  write address.
data_wr  input  DATA_WIDTH  write data.
en_rd  input  1  read request.
addr_rd  input  ADDR_WIDTH  read address.
data_rd  output  DATA_WIDTH  read data; meaningful only while valid_rd = 1.
valid_rd  output  1  data_rd carries the result of the read issued OUTPUT_REG cycles earlier.

Behaviour:
- Reset (rst_n = 0 at a posedge):
  - All pipeline data registers become 0 and all stage valids become 0, so data_rd = 0 and valid_rd = 0.
  - If INIT_CLEAR = 1: FSM goes to CLEAR, clear counter = 0, init_done = 0.
  - If INIT_CLEAR = 0: FSM goes to READY, init_done = 1.
  - RAM contents are not touched by reset itself.
- FSM states: CLEAR and READY.
  - In CLEAR, each posedge with rst_n = 1 writes 0 to ram[cnt] and increments cnt.
  - When cnt == DEPTH-1, that write is the last; the FSM moves to READY and init_done = 1 from the next cycle.
  - So init_done rises exactly DEPTH cycles after the first posedge with rst_n = 1.
  - READY is left only by reset. Reset asserted mid-CLEAR restarts the clear from cnt = 0.
- While init_done = 0: en_wr and en_rd are ignored; no stage valid is launched.
- Write: at a posedge with en_wr = 1 and init_done = 1, for each lane k with be_wr[k] = 1, ram[addr_wr] lane k <= data_wr lane k. Other lanes are unchanged. be_wr = 0 means no change.
- Read launch: at a posedge with en_rd = 1 and init_done = 1, stage0 data <= ram[addr_rd] and stage0 valid <= 1. Otherwise stage0 valid <= 0 and stage0 data holds.
- Pipeline: it advances every cycle with no stall.
  - Stage i valid <= stage i-1 valid.
  - Stage i data loads stage i-1 data only when stage i-1 valid = 1, otherwise it holds.
  - data_rd and valid_rd come from stage OUTPUT_REG-1, so latency = OUTPUT_REG cycles.
  - One read per cycle sustained. data_rd holds the last valid value when valid_rd = 0.
- Out-of-range addresses (>= DEPTH):
  - A write is dropped.
  - A read launches with valid = 1 and data = 0.
- Same-cycle write and read to the same address: the read returns the old word (read-first), unless TP_RAM_BYPASS_EN is defined.
- Reads and writes to different addresses in the same cycle are fully independent.

Optional Feature:
- Macro: TP_RAM_BYPASS_EN.
- Defined: write-first forwarding. When en_wr, en_rd and init_done are all 1 and addr_wr == addr_rd (in range), stage0 data = for each lane, data_wr lane if be_wr[k] else old ram lane. Latency is unchanged. This may force RAM_TYPE "block" to infer extra mux logic; that is acceptable.
- Undefined: read-first behaviour as above.

Test Plan:
1. Clear sequence, defaults, INIT_CLEAR = 1: release rst_n, then poll init_done -> init_done rises exactly 16 cycles after the first non-reset posedge. Reading all 16 addresses afterwards returns 0x00000000 with valid_rd after 1 cycle each.
2. Byte enables: write addr 3 data 0xAABBCCDD be 4'b1111, then data 0x11223344 be 4'b0101, then read addr 3 -> data_rd = 0xAA22CC44, valid_rd high exactly OUTPUT_REG cycles after en_rd.
3. Latency and back-to-back reads, OUTPUT_REG = 3: fill addr 0..7 with 0x100+addr, read 0..7 on consecutive cycles -> valid_rd high for 8 consecutive cycles starting 3 cycles after the first read, data 0x100..0x107 in order. Insert a one-cycle en_rd gap -> matching one-cycle valid_rd gap, and data_rd holds.
4. Collision: addr 5 = 0x0; same cycle write addr 5 = 0xDEADBEEF be 4'b0011 and read addr 5 -> without the macro data_rd = 0x00000000; with TP_RAM_BYPASS_EN data_rd = 0x0000BEEF. A following read gives 0x0000BEEF in both builds.
5. Gating and reset mid-operation: en_wr/en_rd asserted during CLEAR are ignored (no valid_rd, no write). Assert rst_n = 0 mid-clear at cnt = 7 and with reads in flight -> valid_rd = 0, data_rd = 0 next cycle, and init_done rises 16 cycles after release.
6. DEPTH = 12, ADDR_WIDTH = 4: write 0xFFFFFFFF to addr 13 -> no RAM word changes. Read addr 13 -> valid_rd = 1 with data_rd = 0.
